// File: rtl/vga_pkg.sv
// Shared definitions for the VGA colour-code path: FSM state codes, colour
// field positions, write-mask bits, 800x600@72 timing constants and the
// half-merge helper.
package vga_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STAGED = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;

  localparam int LEFT_HI  = 23;
  localparam int LEFT_LO  = 12;
  localparam int RIGHT_HI = 11;
  localparam int RIGHT_LO = 0;

  localparam int MASK_LEFT  = 1;
  localparam int MASK_RIGHT = 0;

  // 800x600@72, 50 MHz pixel clock
  localparam int H_VISIBLE   = 800;
  localparam int H_FRONT_END = 856;
  localparam int H_PULSE_END = 976;
  localparam int H_TOTAL     = 1040;
  localparam int V_VISIBLE   = 600;
  localparam int V_FRONT_END = 637;
  localparam int V_PULSE_END = 643;
  localparam int V_TOTAL     = 666;

  // Overwrite each colour half selected by mask; unselected halves keep cur.
  function automatic logic [23:0] merge_code(input logic [23:0] cur,
                                             input logic [23:0] data,
                                             input logic [1:0]  mask);
    logic [23:0] r;
    r = cur;
    if (mask[MASK_LEFT])  r[LEFT_HI:LEFT_LO]   = data[LEFT_HI:LEFT_LO];
    if (mask[MASK_RIGHT]) r[RIGHT_HI:RIGHT_LO] = data[RIGHT_HI:RIGHT_LO];
    return r;
  endfunction

endpackage

// File: rtl/vga_code_arbiter_if.sv
// Request/ready bundle for the two colour-update ports (0 = CPU, 1 = panel).
// master = requester side, slave = arbiter side.
interface vga_code_arbiter_if;

  logic        req0_valid;
  logic [1:0]  req0_mask;
  logic [23:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [1:0]  req1_mask;
  logic [23:0] req1_data;
  logic        req1_ready;

  modport master (
    output req0_valid, req0_mask, req0_data,
    output req1_valid, req1_mask, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_mask, req0_data,
    input  req1_valid, req1_mask, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester is granted directly;
// on contention the pointer picks the winner. The pointer moves to the
// other port only when the port it points at is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  logic rr_ptr;

  // one-hot grant, never without the matching valid
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // pointer advances after an accept on the pointed-at port
  always_ff @(posedge clk) begin
    if (rst)                 rr_ptr <= 1'b0;
    else if (grant[rr_ptr])  rr_ptr <= ~rr_ptr;
  end

endmodule

// File: rtl/vga_code_arbiter.sv
// Colour-code arbiter for the 800x600 VGA block. Two ports post half-masked
// updates into a staging register; the staged code is committed to code_out
// only on a vsync rising edge so a frame never shows a torn code.
// Optional build macro VGA_BLINK_EN: blanks the right half of code_out on
// alternate BLINK_FRAMES-frame periods.
//
// state     | meaning
// ST_IDLE   | staging equals committed code
// ST_STAGED | staging holds an uncommitted update
// ST_COMMIT | one-cycle commit pulse, ports held off
module vga_code_arbiter
  import vga_pkg::*;
#(
  parameter logic [23:0] RESET_CODE   = 24'h000000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vsync,
  vga_code_arbiter_if.slave    bus,
  output logic [23:0]          code_out,
  output logic                 pending,
  output logic                 frame_done,
  output logic [7:0]           commit_cnt
);

  state_t      state;
  logic [23:0] staging;
  logic [23:0] code_q;
  logic        vsync_d;
  logic        vs_rise;
  logic        ok;
  logic [1:0]  grant;
  logic [1:0]  sel_mask;
  logic [23:0] sel_data;
  logic        write_eff;

  assign vs_rise = vsync & ~vsync_d;
  assign ok      = (state != ST_COMMIT) & ~vs_rise;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .enable (ok),
    .grant  (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  // route the granted port's payload; an empty mask is accepted but inert
  always_comb begin
    sel_mask = grant[1] ? bus.req1_mask : bus.req0_mask;
    sel_data = grant[1] ? bus.req1_data : bus.req0_data;
    if (grant == 2'b00) sel_mask = 2'b00;
    write_eff = |sel_mask;
  end

  // vsync history for edge detect; resets high so reset release is no edge
  always_ff @(posedge clk) begin
    if (rst) vsync_d <= 1'b1;
    else     vsync_d <= vsync;
  end

  // stage / commit FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      staging    <= RESET_CODE;
      code_q     <= RESET_CODE;
      commit_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (write_eff) begin
            staging <= merge_code(staging, sel_data, sel_mask);
            state   <= ST_STAGED;
          end
        end
        ST_STAGED: begin
          if (vs_rise) begin
            code_q <= staging;
            state  <= ST_COMMIT;
          end else if (write_eff) begin
            staging <= merge_code(staging, sel_data, sel_mask);
          end
        end
        ST_COMMIT: begin
          commit_cnt <= commit_cnt + 8'd1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pending    = (state == ST_STAGED);
  assign frame_done = (state == ST_COMMIT);

`ifdef VGA_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  // frame counter 0..BLINK_FRAMES-1, phase flips at each wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (vs_rise) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  assign code_out = blink_phase ? {code_q[LEFT_HI:LEFT_LO], 12'h000} : code_q;
`else
  assign code_out = code_q;

  // blink period has no effect without blinking built in
  if (BLINK_FRAMES < 1) begin : g_blink_frames_unused
  end
`endif

endmodule
